// File: rtl/ysyx_23060240_ifu_if.sv
// Fetch-unit bus bundle: PC-stage input, instruction-memory request/response,
// and the valid/ready instruction channel toward the core, plus flush.
// Ports: master = IFU side, slave = environment side (PC stage, memory, core).
// Latency/backpressure: none (pure wiring bundle).
interface ysyx_23060240_ifu_if;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  fault;

  logic        flush;

  modport master (
    input  pc_in, pc_valid,
    output pc_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    output inst_valid, inst, inst_pc, fault,
    input  inst_ready, flush
  );

  modport slave (
    output pc_in, pc_valid,
    input  pc_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    input  inst_valid, inst, inst_pc, fault,
    output inst_ready, flush
  );
endinterface

// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: one PC in, one memory request, one instruction out (with fault code).
// Latency: PC handshake to inst_valid >= 3 cycles (1 cycle for a misaligned PC); one fetch in flight.
// Backpressure: pc_ready only in IDLE; request held until mem_req_ready; result held until inst_ready.
// Ports: clk, rst (sync, active-high), bus (ysyx_23060240_ifu_if.master: pc_*, mem_req_*, mem_resp_*,
//        inst_*, fault, flush). All outputs come from registered state, gated only by flush/rst.
module ysyx_23060240_ifu #(
  parameter int TIMEOUT = 16  // WAIT cycles before a timeout fault, 1..255
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_23060240_ifu_if.master       bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [1:0] F_NONE     = 2'b00;
  localparam logic [1:0] F_MISALIGN = 2'b01;
  localparam logic [1:0] F_BUS      = 2'b10;
  localparam logic [1:0] F_TMO      = 2'b11;
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [1:0]  fault_q;
  logic [7:0]  cnt_q;
  logic        drop_q;

  logic        pc_fire;
  logic        req_fire;
  logic        pc_ld;
  logic        cap_ld;
  logic [31:0] inst_d;
  logic [1:0]  fault_d;
  logic        cnt_clr;
  logic        drop_set;

  // Output decode: registered state, with same-cycle gating by flush and rst.
  assign bus.pc_ready      = (state_q == IDLE) && !rst && !bus.flush;
  assign bus.mem_req_valid = (state_q == REQ) && !drop_q && !bus.flush && !rst;
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = (state_q == HOLD) && !bus.flush && !rst;
  assign bus.inst          = rst ? 32'h0 : inst_q;
  assign bus.inst_pc       = rst ? 32'h0 : pc_q;
  assign bus.fault         = rst ? F_NONE : fault_q;

  assign pc_fire  = bus.pc_valid && bus.pc_ready;
  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;

  always_comb begin
    state_d  = state_q;
    pc_ld    = 1'b0;
    cap_ld   = 1'b0;
    inst_d   = 32'h0;
    fault_d  = F_NONE;
    cnt_clr  = 1'b0;
    drop_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (pc_fire) begin
          pc_ld = 1'b1;
          if (bus.pc_in[1:0] != 2'b00) begin
            // Misaligned: report straight away, never touch memory.
            state_d = HOLD;
            cap_ld  = 1'b1;
            fault_d = F_MISALIGN;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
          cnt_clr = 1'b1;
        end
      end
      WAIT: begin
        // A response in the timeout cycle still wins over the timeout.
        if (bus.mem_resp_valid) begin
          state_d = HOLD;
          cap_ld  = 1'b1;
          inst_d  = bus.mem_resp_err ? 32'h0 : bus.mem_resp_data;
          fault_d = bus.mem_resp_err ? F_BUS : F_NONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HOLD;
          cap_ld   = 1'b1;
          fault_d  = F_TMO;
          drop_set = 1'b1;  // the response is still owed; swallow it later
        end
      end
      HOLD: begin
        if (bus.inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush abandons whatever is in progress. A flushed WAIT leaves a stale
    // response outstanding unless that response is arriving right now.
    if (bus.flush) begin
      state_d  = IDLE;
      pc_ld    = 1'b0;
      cap_ld   = 1'b0;
      cnt_clr  = 1'b0;
      drop_set = (state_q == WAIT) && !bus.mem_resp_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= 32'h0;
      inst_q  <= 32'h0;
      fault_q <= F_NONE;
      cnt_q   <= 8'h0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_ld) pc_q <= bus.pc_in;
      if (cap_ld) begin
        inst_q  <= inst_d;
        fault_q <= fault_d;
      end
      if (cnt_clr) cnt_q <= 8'h0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 8'd1;
      // WAIT is only entered with drop clear, so set and clear never collide.
      if (drop_q && bus.mem_resp_valid) drop_q <= 1'b0;
      else if (drop_set) drop_q <= 1'b1;
    end
  end

endmodule
